// File: rtl/reaction_pkg.sv
// Shared constants for the reaction-test timer and its controlling FSM.
package reaction_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int TICK_DIV_DEF   = 100000;
  localparam int RWAIT_MIN_DEF  = 1000;
  localparam int RWAIT_BITS_DEF = 12;
  localparam int WAIT5_DEF      = 5000;
  localparam int LATE_DEF       = 1000;
  localparam int TW_DEF         = 14;

  typedef enum logic {
    LED_OFF = 1'b0,
    LED_ON  = 1'b1
  } led_e;

  // Right-shifting Galois form; a nonzero seed never reaches zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/reaction_timer_ms_tick.sv
// Millisecond prescaler: one-cycle tick every DIV clocks, held off by clr.
module ms_tick #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/reaction_timer.sv
// Timing datapath for the reaction test: random wait, hold timer,
// ms reaction counter and last/best result capture.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int TICK_DIV        = TICK_DIV_DEF,
  parameter int RWAIT_MIN_MS    = RWAIT_MIN_DEF,
  parameter int RWAIT_RAND_BITS = RWAIT_BITS_DEF,
  parameter int WAIT5_MS        = WAIT5_DEF,
  parameter int LATE_MS         = LATE_DEF,
  parameter int TW              = TW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_rwait,
  input  logic          start_wait5,
  input  logic          time_clr,
  input  logic          time_en,
  input  logic          rs_en,
  output logic          rwait_done,
  output logic          wait5_done,
  output logic          time_late,
  output logic [TW-1:0] time_ms,
  output logic [TW-1:0] result_ms,
  output logic [TW-1:0] best_ms,
  output logic          best_valid
);

  logic [15:0]   lfsr;
  logic          tick_free;
  logic          tick_rt;
  logic          time_clr_q;
  logic          rs_en_q;
  logic          arm;
  logic          capture;
  logic          rwait_act;
  logic [TW-1:0] rwait_cnt;
  logic [TW-1:0] rwait_load;
  logic [TW-1:0] w5_cnt;

  ms_tick #(.DIV(TICK_DIV)) u_tick_free (
    .clk  (clk),
    .rst  (rst),
    .clr  (1'b0),
    .tick (tick_free)
  );

  ms_tick #(.DIV(TICK_DIV)) u_tick_rt (
    .clk  (clk),
    .rst  (rst),
    .clr  (time_clr),
    .tick (tick_rt)
  );

  // Entering the wait via a counter clear also arms it.
  assign arm     = start_rwait | (time_clr & ~time_clr_q);
  assign capture = rs_en & ~rs_en_q;

  assign rwait_load = TW'(RWAIT_MIN_MS)
                    + TW'(lfsr[RWAIT_RAND_BITS-1:0]);

  assign time_late = (time_ms >= TW'(LATE_MS));

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= LFSR_SEED;
      time_clr_q <= 1'b0;
      rs_en_q    <= 1'b0;
    end else begin
      lfsr       <= lfsr_next(lfsr);
      time_clr_q <= time_clr;
      rs_en_q    <= rs_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rwait_cnt  <= '0;
      rwait_act  <= 1'b0;
      rwait_done <= 1'b0;
    end else if (arm) begin
      rwait_cnt  <= rwait_load;
      rwait_act  <= 1'b1;
      rwait_done <= 1'b0;
    end else if (rwait_act && tick_free) begin
      if (rwait_cnt <= TW'(1)) begin
        rwait_cnt  <= '0;
        rwait_act  <= 1'b0;
        rwait_done <= 1'b1;
      end else begin
        rwait_cnt <= rwait_cnt - TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !start_wait5) begin
      w5_cnt     <= '0;
      wait5_done <= 1'b0;
    end else if (tick_free && !wait5_done) begin
      w5_cnt <= w5_cnt + TW'(1);
      if ((w5_cnt + TW'(1)) == TW'(WAIT5_MS)) begin
        wait5_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || time_clr) begin
      time_ms <= '0;
    end else if (time_en && tick_rt && (time_ms != '1)) begin
      time_ms <= time_ms + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_ms  <= '0;
      best_ms    <= '1;
      best_valid <= 1'b0;
    end else if (capture) begin
      result_ms <= time_ms;
      if (!best_valid || (time_ms < best_ms)) begin
        best_ms    <= time_ms;
        best_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with a scaled-down tick.
module tb_reaction_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_rwait;
  logic       start_wait5;
  logic       time_clr;
  logic       time_en;
  logic       rs_en;
  logic       rwait_done;
  logic       wait5_done;
  logic       time_late;
  logic [3:0] time_ms;
  logic [3:0] result_ms;
  logic [3:0] best_ms;
  logic       best_valid;

  reaction_timer #(
    .TICK_DIV        (4),
    .RWAIT_MIN_MS    (3),
    .RWAIT_RAND_BITS (2),
    .WAIT5_MS        (5),
    .LATE_MS         (6),
    .TW              (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_rwait (start_rwait),
    .start_wait5 (start_wait5),
    .time_clr    (time_clr),
    .time_en     (time_en),
    .rs_en       (rs_en),
    .rwait_done  (rwait_done),
    .wait5_done  (wait5_done),
    .time_late   (time_late),
    .time_ms     (time_ms),
    .result_ms   (result_ms),
    .best_ms     (best_ms),
    .best_valid  (best_valid)
  );

  always #5 clk = ~clk;

  // Reference LFSR, x^16+x^14+x^13+x^11 Galois, seeded on reset.
  logic [15:0] m;
  always @(posedge clk) begin
    if (rst) m <= 16'hACE1;
    else     m <= m[0] ? ((m >> 1) ^ 16'hB400) : (m >> 1);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tickn(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic clr;
    logic en;
    logic rs;
    int   n;
    int   t;
    logic late;
    int   res;
    int   best;
    logic valid;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic e,
                              input logic r, input int n,
                              input int t, input logic l,
                              input int res, input int best,
                              input logic v);
    vec_t x;
    x.clr = c; x.en = e; x.rs = r; x.n = n; x.t = t;
    x.late = l; x.res = res; x.best = best; x.valid = v;
    return x;
  endfunction

  vec_t tbl[16];

  int k;
  int lo;
  int hi;
  int nt;

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0,  1,  0, 1'b0, 0, 15, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 20,  5, 1'b0, 0, 15, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1,  2,  5, 1'b0, 5,  5, 1'b1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1,  8,  7, 1'b1, 5,  5, 1'b1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0,  1,  7, 1'b1, 5,  5, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1,  1,  7, 1'b1, 7,  5, 1'b1);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0,  1,  0, 1'b0, 7,  5, 1'b1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 12,  3, 1'b0, 7,  5, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b1,  1,  3, 1'b0, 3,  3, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0,  1,  0, 1'b0, 3,  3, 1'b1);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 23,  5, 1'b0, 3,  3, 1'b1);
    tbl[11] = mk(1'b0, 1'b1, 1'b0,  1,  6, 1'b1, 3,  3, 1'b1);
    tbl[12] = mk(1'b0, 1'b1, 1'b0, 40, 15, 1'b1, 3,  3, 1'b1);
    tbl[13] = mk(1'b1, 1'b1, 1'b0,  1,  0, 1'b0, 3,  3, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 1'b0,  3,  0, 1'b0, 3,  3, 1'b1);
    tbl[15] = mk(1'b0, 1'b1, 1'b0,  1,  1, 1'b0, 3,  3, 1'b1);

    rst = 1'b1;
    start_rwait = 1'b0;
    start_wait5 = 1'b0;
    time_clr = 1'b0;
    time_en = 1'b0;
    rs_en = 1'b0;
    tickn(3);
    check("rst_rwait_done", 32'(rwait_done), 0);
    check("rst_wait5_done", 32'(wait5_done), 0);
    check("rst_time_late", 32'(time_late), 0);
    check("rst_time_ms", 32'(time_ms), 0);
    check("rst_result_ms", 32'(result_ms), 0);
    check("rst_best_ms", 32'(best_ms), 15);
    check("rst_best_valid", 32'(best_valid), 0);
    rst = 1'b0;
    tickn(2);

    // Random wait: expiry after (3 + r) ticks of the free prescaler.
    start_rwait = 1'b1;
    nt = 3 + int'(m[1:0]);
    tickn(1);
    start_rwait = 1'b0;
    k = 0;
    while (!rwait_done && k < 60) begin
      tickn(1);
      k++;
    end
    lo = nt * 4 - 4;
    hi = nt * 4 + 4;
    check("rwait_expiry_window", 32'(k >= lo && k <= hi), 1);
    tickn(8);
    check("rwait_sticky", 32'(rwait_done), 1);
    time_clr = 1'b1;
    tickn(1);
    check("rwait_rearm_clear", 32'(rwait_done), 0);
    time_clr = 1'b0;
    tickn(1);

    for (int i = 0; i < 16; i++) begin
      time_clr = tbl[i].clr;
      time_en  = tbl[i].en;
      rs_en    = tbl[i].rs;
      tickn(tbl[i].n);
      check($sformatf("vec%0d_time_ms", i), 32'(time_ms), tbl[i].t);
      check($sformatf("vec%0d_late", i), 32'(time_late),
            32'(tbl[i].late));
      check($sformatf("vec%0d_result", i), 32'(result_ms), tbl[i].res);
      check($sformatf("vec%0d_best", i), 32'(best_ms), tbl[i].best);
      check($sformatf("vec%0d_valid", i), 32'(best_valid),
            32'(tbl[i].valid));
    end
    time_clr = 1'b0;
    time_en  = 1'b0;
    rs_en    = 1'b0;
    tickn(1);

    // Hold timer: five free ticks, sticky, restart after a drop.
    check("wait5_idle", 32'(wait5_done), 0);
    for (int pass = 0; pass < 2; pass++) begin
      start_wait5 = 1'b1;
      k = 0;
      while (!wait5_done && k < 40) begin
        tickn(1);
        k++;
      end
      check($sformatf("wait5_window%0d", pass),
            32'(k >= 17 && k <= 20), 1);
      tickn(10);
      check($sformatf("wait5_sticky%0d", pass), 32'(wait5_done), 1);
      start_wait5 = 1'b0;
      tickn(1);
      check($sformatf("wait5_drop%0d", pass), 32'(wait5_done), 0);
    end

    // Reset in the middle of an active random wait.
    start_rwait = 1'b1;
    tickn(1);
    start_rwait = 1'b0;
    tickn(5);
    rst = 1'b1;
    tickn(1);
    check("mid_rst_rwait_done", 32'(rwait_done), 0);
    check("mid_rst_time_ms", 32'(time_ms), 0);
    check("mid_rst_result", 32'(result_ms), 0);
    check("mid_rst_best", 32'(best_ms), 15);
    check("mid_rst_valid", 32'(best_valid), 0);
    rst = 1'b0;
    tickn(60);
    check("mid_rst_no_expiry", 32'(rwait_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
